leaf_stream_fifo: RTL and testbench

Leaf stage of the generated module tree: the block instantiated beneath the lowest `_se9_*` level, giving each leaf instance a real sequential workload. It buffers a valid/ready byte stream in a small circular FIFO and presents it downstream in order. Optionally, it folds every delivered word into a rotating XOR signature, so the hierarchy tests can compare leaves after simulation or synthesis.

---
 rtl/leaf_stream_fifo.sv | 70 +++++++
 tb/tb_leaf_stream_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_fifo.sv
// Leaf stage: small circular valid/ready FIFO with an optional delivered-word signature.
// Define LEAF_FIFO_SIG_EN to build the rotating XOR signature; otherwise sig is tied to 0.
module leaf_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DATA_W-1:0]          sig
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Readiness comes from registered occupancy only, never from out_ready.
    assign in_ready  = !rst && (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef LEAF_FIFO_SIG_EN
    logic [DATA_W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst)
            sig_q <= '0;
        else if (pop)
            sig_q <= {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ out_data;
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Directed self-checking bench for leaf_stream_fifo (DATA_W=8, DEPTH=4).
module tb_leaf_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic [DW-1:0] sig;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_sig = '0;

    leaf_stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fold(input logic [DW-1:0] s, input logic [DW-1:0] d);
        return {s[DW-2:0], s[DW-1]} ^ d;
    endfunction

    function automatic logic [DW-1:0] sig_ref();
`ifdef LEAF_FIFO_SIG_EN
        return exp_sig;
`else
        return '0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_sig = '0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        exp_sig = '0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL reset_state: valid %b count %0d expected 0 0", out_valid, count);
        end
        checks++;
        if (out_data !== 8'h00 || sig !== 8'h00) begin
            errors++; $display("FAIL reset_data: data %h sig %h expected 00 00", out_data, sig);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_push: valid %b data %h count %0d expected 1 a5 1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_sig = fold(exp_sig, 8'hA5);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: valid %b data %h count %0d expected 0 00 0", out_valid, out_data, count);
        end
        checks++;
        if (sig !== sig_ref()) begin
            errors++; $display("FAIL single_sig: got %h expected %h", sig, sig_ref());
        end
    endtask

    task automatic test_fill_wrap();
        logic [DW-1:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: count %0d ready %b expected 4 0", count, in_ready);
        end
        in_data = 8'h05;
        step();
        checks++;
        if (count !== 3'd4) begin
            errors++; $display("FAIL fill_no_push: count %0d expected 4", count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_sig = fold(exp_sig, 8'h01);
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_data !== 8'h02) begin
            errors++;
            $display("FAIL fill_pop_one: count %0d ready %b data %h expected 3 1 02", count, in_ready, out_data);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++; $display("FAIL fill_wrap_push: count %0d expected 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data !== exp_q[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fill_drain_%0d: data %h valid %b expected %h 1", i, out_data, out_valid, exp_q[i]);
            end
            step();
            exp_sig = fold(exp_sig, exp_q[i]);
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || sig !== sig_ref()) begin
            errors++;
            $display("FAIL fill_end: count %0d sig %h expected 0 %h", count, sig, sig_ref());
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] exp_q [3];
        exp_q = '{8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DW'(8'h10 + i);
            step();
        end
        in_data = 8'h14; out_ready = 1'b1;
        step();
        exp_sig = fold(exp_sig, 8'h10);
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL full_pop_only: count %0d expected 3", count);
        end
        step();
        in_valid = 1'b0;
        exp_sig = fold(exp_sig, 8'h11);
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL full_push_pop: count %0d expected 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data !== exp_q[i]) begin
                errors++;
                $display("FAIL full_drain_%0d: data %h expected %h", i, out_data, exp_q[i]);
            end
            step();
            exp_sig = fold(exp_sig, exp_q[i]);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sig !== sig_ref()) begin
            errors++;
            $display("FAIL full_end: valid %b sig %h expected 0 %h", out_valid, sig, sig_ref());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = DW'(i);
            step();
            if (i > 0) exp_sig = fold(exp_sig, DW'(i - 1));
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || count !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d: valid %b data %h count %0d expected 1 %h 1", i, out_valid, out_data, count, DW'(i));
            end
            checks++;
            if (sig !== sig_ref()) begin
                errors++; $display("FAIL stream_sig_%0d: got %h expected %h", i, sig, sig_ref());
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        exp_sig = fold(exp_sig, 8'h13);
        checks++;
        if (count !== 3'd0 || sig !== sig_ref()) begin
            errors++;
            $display("FAIL stream_end: count %0d sig %h expected 0 %h", count, sig, sig_ref());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++; $display("FAIL mid_fill: count %0d expected 3", count);
        end
        rst = 1'b1; in_data = 8'h04; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready: got %b expected 0", in_ready);
        end
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_sig = '0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || sig !== 8'h00) begin
            errors++;
            $display("FAIL mid_cleared: count %0d valid %b data %h sig %h expected 0 0 00 00", count, out_valid, out_data, sig);
        end
        in_valid = 1'b1; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'h77 || count !== 3'd1) begin
            errors++; $display("FAIL mid_fresh: data %h count %0d expected 77 1", out_data, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_drain: valid %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
